// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit XNOR LFSR generator and checker.
// Holds the width, lockup value, checker state encoding and step function.
package lfsr_pkg;

  localparam int LFSR_W = 4;

  localparam logic [LFSR_W-1:0] LOCKUP_VAL = 4'hF;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_e;

  // XNOR feedback: all-ones maps to itself, so it never appears in sequence.
  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] x
  );
    return {x[2:0], ~(x[3] ^ x[2])};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational one-step advance of the 4-bit XNOR LFSR.
// Ports: cur (present value) -> nxt (following value).
module lfsr_step
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic [LFSR_W-1:0] nxt
);

  assign nxt = lfsr_next(cur);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for a 4-bit XNOR LFSR sample stream.
// Ports: clock/reset, sample_in/valid, clear_count in; lock/error/lockup out.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT = 3,
  parameter int LOSS_COUNT = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [LFSR_W-1:0]    sample_in,
  input  logic                 sample_valid,
  input  logic                 clear_count,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [ERR_CNT_W-1:0] error_count,
  output logic                 lockup_detect,
  output logic [LFSR_W-1:0]    expected
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int NW = $clog2(LOSS_COUNT + 1);

  state_e                 state_q, state_d;
  logic [LFSR_W-1:0]      exp_q, exp_d;
  logic [MW-1:0]          match_q, match_d;
  logic [NW-1:0]          miss_q, miss_d;
  logic                   locked_q, locked_d;
  logic                   pulse_q, pulse_d;
  logic                   lockup_q, lockup_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;

  logic [LFSR_W-1:0]      seed_nxt;
  logic [LFSR_W-1:0]      pred_nxt;
  logic                   is_hit;
  logic                   is_lockup;
  logic [MW-1:0]          match_inc;
  logic [NW-1:0]          miss_inc;

  lfsr_step u_seed (
    .cur (sample_in),
    .nxt (seed_nxt)
  );

  lfsr_step u_pred (
    .cur (exp_q),
    .nxt (pred_nxt)
  );

  assign is_hit    = (sample_in == exp_q);
  assign is_lockup = (sample_in == LOCKUP_VAL);
  assign match_inc = match_q + MW'(1);
  assign miss_inc  = miss_q + NW'(1);

  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    lockup_d = 1'b0;
    err_d    = err_q;
    if (sample_valid) begin
      unique case (state_q)
        HUNT: begin
          if (is_lockup) begin
            lockup_d = 1'b1;
          end else begin
            exp_d   = seed_nxt;
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (is_hit) begin
            exp_d   = pred_nxt;
            match_d = match_inc;
            if (match_inc == MW'(LOCK_COUNT)) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else if (is_lockup) begin
            lockup_d = 1'b1;
            state_d  = HUNT;
          end else begin
            exp_d   = seed_nxt;
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: keep predicting even through bad samples.
          exp_d    = pred_nxt;
          lockup_d = is_lockup;
          if (is_hit) begin
            miss_d = '0;
          end else begin
            pulse_d = 1'b1;
            if (err_q != '1) begin
              err_d = err_q + ERR_CNT_W'(1);
            end
            miss_d = miss_inc;
            if (miss_inc == NW'(LOSS_COUNT)) begin
              state_d  = HUNT;
              locked_d = 1'b0;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
        end
      endcase
    end
    if (clear_count) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      lockup_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      lockup_q <= lockup_d;
      err_q    <= err_d;
    end
  end

  assign locked        = locked_q;
  assign error_pulse   = pulse_q;
  assign error_count   = err_q;
  assign lockup_detect = lockup_q;
  assign expected      = exp_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: directed vector table, hand sequences, random run.
// Two instances share stimulus: default widths and a 2-bit error counter.
module tb_lfsr_checker;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sample_in = 4'h0;
  logic       sample_valid = 1'b0;
  logic       clear_count = 1'b0;

  logic       locked, pulse, lockup;
  logic [7:0] ecnt;
  logic [3:0] expd;
  logic       locked2, pulse2, lockup2;
  logic [1:0] ecnt2;
  logic [3:0] expd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  lfsr_checker dut (
    .clock         (clock),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .clear_count   (clear_count),
    .locked        (locked),
    .error_pulse   (pulse),
    .error_count   (ecnt),
    .lockup_detect (lockup),
    .expected      (expd)
  );

  lfsr_checker #(.ERR_CNT_W(2)) dut2 (
    .clock         (clock),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .clear_count   (clear_count),
    .locked        (locked2),
    .error_pulse   (pulse2),
    .error_count   (ecnt2),
    .lockup_detect (lockup2),
    .expected      (expd2)
  );

  // Model: position in the 15-long sequence plus a run counter per mode.
  int seq [15];
  int m_mode;
  int m_pos;
  int m_run;
  int m_err8;
  int m_err2;
  bit m_pulse;
  bit m_lk;

  function automatic int idx_of(int v);
    for (int i = 0; i < 15; i++)
      if (seq[i] == v) return i;
    return -1;
  endfunction

  function automatic int sat_inc(int v, int mx);
    return (v < mx) ? v + 1 : v;
  endfunction

  task automatic model_step(bit v, int s, bit c, bit r);
    m_pulse = 0;
    m_lk = 0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_run = 0;
      m_err8 = 0; m_err2 = 0;
      return;
    end
    if (v) begin
      if (m_mode == 0) begin
        if (s == 15) m_lk = 1;
        else begin
          m_pos = (idx_of(s) + 1) % 15;
          m_run = 0;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (s == seq[m_pos]) begin
          m_pos = (m_pos + 1) % 15;
          m_run++;
          if (m_run == 3) begin
            m_mode = 2;
            m_run = 0;
          end
        end else if (s == 15) begin
          m_lk = 1;
          m_mode = 0;
        end else begin
          m_pos = (idx_of(s) + 1) % 15;
          m_run = 0;
        end
      end else begin
        bit hit;
        hit = (s == seq[m_pos]);
        m_pos = (m_pos + 1) % 15;
        m_lk = (s == 15);
        if (hit) m_run = 0;
        else begin
          m_pulse = 1;
          m_err8 = sat_inc(m_err8, 255);
          m_err2 = sat_inc(m_err2, 3);
          m_run++;
          if (m_run == 4) m_mode = 0;
        end
      end
    end
    if (c) begin
      m_err8 = 0;
      m_err2 = 0;
    end
  endtask

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cycle(bit v, logic [3:0] s, bit c, bit r);
    sample_valid = v;
    sample_in    = s;
    clear_count  = c;
    reset        = r;
    @(posedge clock);
    model_step(v, int'(s), c, r);
    #1;
    chk("m_locked", int'(locked), int'(m_mode == 2));
    chk("m_pulse", int'(pulse), int'(m_pulse));
    chk("m_cnt", int'(ecnt), m_err8);
    chk("m_lockup", int'(lockup), int'(m_lk));
    chk("m_exp", int'(expd), seq[m_pos]);
    chk("m2_locked", int'(locked2), int'(m_mode == 2));
    chk("m2_pulse", int'(pulse2), int'(m_pulse));
    chk("m2_cnt", int'(ecnt2), m_err2);
    chk("m2_lockup", int'(lockup2), int'(m_lk));
    chk("m2_exp", int'(expd2), seq[m_pos]);
    reset = 1'b0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_pulse"}, int'(pulse), 0);
    chk({tag, "_cnt"}, int'(ecnt), 0);
    chk({tag, "_lockup"}, int'(lockup), 0);
    chk({tag, "_exp"}, int'(expd), 0);
  endtask

  task automatic lock_seq(int gap);
    logic [3:0] lv [4];
    lv[0] = 4'h0; lv[1] = 4'h1;
    lv[2] = 4'h3; lv[3] = 4'h7;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, lv[i], 1'b0, 1'b0);
      chk($sformatf("lk%0d_locked", i),
          int'(locked), int'(i == 3));
      for (int g = 0; g < gap && i < 3; g++)
        cycle(1'b0, 4'h9, 1'b0, 1'b0);
    end
    chk("lk_exp", int'(expd), 14);
    chk("lk_cnt", int'(ecnt), 0);
  endtask

  typedef struct {
    bit         v;
    logic [3:0] s;
    bit         c;
    bit         lo;
    bit         pl;
    int         cnt;
    bit         lu;
    logic [3:0] ex;
  } vec_t;

  vec_t tab [18];

  initial begin
    int x;
    x = 0;
    for (int i = 0; i < 15; i++) begin
      seq[i] = x;
      x = ((x << 1) & 15) | (~((x >> 3) ^ (x >> 2)) & 1);
    end

    //          v  s     c  lo pl cnt lu ex
    tab[0]  = '{1, 4'h0, 0, 0, 0, 0, 0, 4'h1};
    tab[1]  = '{1, 4'h1, 0, 0, 0, 0, 0, 4'h3};
    tab[2]  = '{1, 4'h3, 0, 0, 0, 0, 0, 4'h7};
    tab[3]  = '{1, 4'h7, 0, 1, 0, 0, 0, 4'hE};
    tab[4]  = '{1, 4'h5, 0, 1, 1, 1, 0, 4'hD};
    tab[5]  = '{1, 4'hD, 0, 1, 0, 1, 0, 4'hB};
    tab[6]  = '{1, 4'hB, 0, 1, 0, 1, 0, 4'h6};
    tab[7]  = '{1, 4'h6, 0, 1, 0, 1, 0, 4'hC};
    tab[8]  = '{0, 4'h0, 1, 1, 0, 0, 0, 4'hC};
    tab[9]  = '{1, 4'h0, 0, 1, 1, 1, 0, 4'h9};
    tab[10] = '{1, 4'h0, 0, 1, 1, 2, 0, 4'h2};
    tab[11] = '{1, 4'h0, 0, 1, 1, 3, 0, 4'h5};
    tab[12] = '{1, 4'h0, 0, 0, 1, 4, 0, 4'hA};
    tab[13] = '{1, 4'h2, 0, 0, 0, 4, 0, 4'h5};
    tab[14] = '{1, 4'hF, 0, 0, 0, 4, 1, 4'h5};
    tab[15] = '{1, 4'hF, 0, 0, 0, 4, 1, 4'h5};
    tab[16] = '{1, 4'h0, 0, 0, 0, 4, 0, 4'h1};
    tab[17] = '{1, 4'hF, 0, 0, 0, 4, 1, 4'h1};

    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    chk_zero("rst");

    for (int i = 0; i < 18; i++) begin
      cycle(tab[i].v, tab[i].s, tab[i].c, 1'b0);
      chk($sformatf("t%0d_locked", i), int'(locked), int'(tab[i].lo));
      chk($sformatf("t%0d_pulse", i), int'(pulse), int'(tab[i].pl));
      chk($sformatf("t%0d_cnt", i), int'(ecnt), tab[i].cnt);
      chk($sformatf("t%0d_lockup", i), int'(lockup), int'(tab[i].lu));
      chk($sformatf("t%0d_exp", i), int'(expd), int'(tab[i].ex));
    end

    // Saturation of the 2-bit counter, then clear beating an increment.
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    lock_seq(0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 4'(seq[m_pos] ^ 1), 1'b0, 1'b0);
      chk("sat_pulse", int'(pulse2), 1);
      cycle(1'b1, 4'(seq[m_pos]), 1'b0, 1'b0);
    end
    chk("sat_cnt2", int'(ecnt2), 3);
    chk("sat_cnt8", int'(ecnt), 5);
    chk("sat_locked", int'(locked2), 1);
    cycle(1'b1, 4'(seq[m_pos] ^ 1), 1'b1, 1'b0);
    chk("clr_cnt2", int'(ecnt2), 0);
    chk("clr_pulse2", int'(pulse2), 1);
    chk("clr_cnt8", int'(ecnt), 0);

    // Same lock with idle gaps, then reset while locked.
    cycle(1'b0, 4'h0, 1'b0, 1'b1);
    lock_seq(3);
    cycle(1'b1, 4'h3, 1'b0, 1'b0);
    chk("pre_rst_pulse", int'(pulse), 1);
    cycle(1'b1, 4'h0, 1'b0, 1'b1);
    chk_zero("lrst");

    // Random run biased towards correct samples so lock is exercised.
    for (int n = 0; n < 2000; n++) begin
      int  p;
      bit  v, c, r;
      logic [3:0] s;
      p = int'($urandom_range(99, 0));
      v = ($urandom_range(99, 0) < 80);
      c = ($urandom_range(99, 0) < 3);
      r = ($urandom_range(999, 0) < 5);
      if (p < 75) s = 4'(seq[m_pos]);
      else if (p < 80) s = 4'hF;
      else s = 4'($urandom_range(15, 0));
      cycle(v, s, c, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side counterpart of the team's 4-bit XNOR LFSR random-number generator. It consumes a stream of 4-bit samples and self-synchronises to the LFSR sequence, where the next value is {r[2:0], ~(r[3]^r[2])}. Once synchronised, it flags and counts every sample that departs from the expected sequence. It sits at the consumer end of a link or test path and acts as a pattern checker for generator output.

Parameters:
LOCK_COUNT, 3, consecutive correct predictions after seeding required to declare lock (min 1)
LOSS_COUNT, 4, consecutive mismatches while locked that force return to hunt (min 1)
ERR_CNT_W, 8, width of saturating error counter

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
sample_in  input  4  received LFSR value
sample_valid  input  1  sample_in qualifier; block state changes only on valid cycles (except reset/clear_count)
clear_count  input  1  synchronous clear of error_count
locked  output  1  high while in LOCKED state
error_pulse  output  1  one-cycle pulse per mismatched valid sample while LOCKED
error_count  output  ERR_CNT_W  saturating count of mismatches seen while LOCKED
lockup_detect  output  1  one-cycle pulse when 4'b1111 (XNOR lockup value) is received
expected  output  4  currently predicted next sample

Behaviour:
- Reset, synchronous and active-high: state=HUNT; expected=0; match_cnt=0; miss_cnt=0; locked=0; error_pulse=0; error_count=0; lockup_detect=0. Reset mid-operation aborts lock immediately on that edge.
- All outputs are registered and reflect the edge on which the valid sample was taken.
- sample_valid=0: all state held; error_pulse and lockup_detect are 0.
- next(x) = {x[2:0], ~(x[3]^x[2])}. Sequence period is 15; 4'hF is never produced.
- HUNT:
  - valid sample = 4'hF: lockup_detect=1, stay in HUNT.
  - Otherwise: expected<=next(sample), match_cnt<=0, go to VERIFY.
- VERIFY:
  - valid sample = expected: expected<=next(expected), match_cnt++.
  - If match_cnt reaches LOCK_COUNT on that sample: go to LOCKED, locked<=1, miss_cnt<=0.
  - Mismatch with sample=4'hF: lockup_detect=1, go to HUNT.
  - Other mismatch: reseed, i.e. expected<=next(sample), match_cnt<=0, stay in VERIFY.
  - error_count and error_pulse are never affected in VERIFY.
- LOCKED (flywheel):
  - Every valid sample: expected<=next(expected), regardless of match.
  - Match: miss_cnt<=0.
  - Mismatch: error_pulse=1, error_count+1 saturating at all-ones, miss_cnt++.
  - When miss_cnt reaches LOSS_COUNT: go to HUNT, locked<=0. The LOSS_COUNT-th mismatch is still counted.
  - Received 4'hF also pulses lockup_detect (in addition to counting as a mismatch).
- clear_count=1: error_count<=0. Clear wins over a simultaneous increment. Does not affect the state machine.
- Lock latency: locked rises on the edge of the (LOCK_COUNT+1)-th consecutive consistent valid sample (seed plus LOCK_COUNT).

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=4
  - LOCKUP_VAL=4'hF
  - State enum {HUNT, VERIFY, LOCKED}
  - lfsr_next function (shared with the generator)
- One natural sub-module: lfsr_step. This is the combinational next-value function, instantiated twice: once on sample_in for seeding and once on expected for prediction.
- Counters and the FSM stay in lfsr_checker.

Test Plan:
- Lock: reset, then feed valid 0,1,3,7 → locked=0 after 0,1,3 and locked=1 after 7; expected=4'hE; error_count=0.
- Flywheel error: locked at expected 4'hE; feed 4'h5, then continue correctly with D,B,6 → error_pulse for exactly 1 cycle, error_count=1, locked stays 1, expected tracks B,6,C.
- Loss of lock, LOSS_COUNT=4: while locked, feed 4 consecutive wrong samples (e.g. 0,0,0,0 where 0 is not predicted) → error_count=4, locked drops on the 4th edge; next valid 4'h2 reseeds with expected=4'h5.
- Lockup handling: in HUNT feed 4'hF → lockup_detect pulse, still in HUNT; in VERIFY after seed 0 feed 4'hF → lockup_detect, return to HUNT, locked=0.
- Saturation and clear, ERR_CNT_W=2: while locked force 5 isolated mismatches (each followed by a correct sample) → error_count sticks at 3. Then clear_count together with a mismatch → error_count=0 and error_pulse=1.
- Gaps and reset: lock sequence 0,1,3,7 with sample_valid low for 3 cycles between samples → identical lock result. Assert reset while locked → all outputs 0 on the next edge.
